// File: rtl/reduce_pkg.sv
// Shared definitions for reduce_gate_bist: mode and BIST state encodings, plus the
// golden reduction model used by the self-test compare.
package reduce_pkg;

   typedef enum logic [1:0] {
      MODE_OR  = 2'b00,
      MODE_AND = 2'b01,
      MODE_XOR = 2'b10,
      MODE_NOR = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_APPLY = 2'b01,
      ST_FLUSH = 2'b10,
      ST_DONE  = 2'b11
   } bist_state_e;

   // Bit-serial model, deliberately unlike the core's reduction operators.
   function automatic logic golden_reduce(input logic [15:0] data,
                                          input int unsigned width,
                                          input logic [1:0] mode);
      logic any_one;
      logic all_one;
      logic parity;
      logic res;
      any_one = 1'b0;
      all_one = 1'b1;
      parity  = 1'b0;
      for (int unsigned i = 0; i < width && i < 16; i++) begin
         any_one = any_one | data[i[3:0]];
         all_one = all_one & data[i[3:0]];
         parity  = parity ^ data[i[3:0]];
      end
      case (mode_e'(mode))
         MODE_OR:  res = any_one;
         MODE_AND: res = all_one;
         MODE_XOR: res = parity;
         MODE_NOR: res = ~any_one;
         default:  res = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/reduce_gate_bist_core.sv
// reduce_core: mode-selected N-input reduction with a load-enabled output register.
module reduce_core
   import reduce_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] data,
   input  logic [1:0]       mode,
   output logic             result
);

   logic red;

   always_comb begin
      red = 1'b0;
      case (mode_e'(mode))
         MODE_OR:  red = |data;
         MODE_AND: red = &data;
         MODE_XOR: red = ^data;
         MODE_NOR: red = ~|data;
         default:  red = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         result <= 1'b0;
      end else if (load) begin
         result <= red;
      end
   end

endmodule

// File: rtl/reduce_gate_bist.sv
// Registered N-input reduction gate with OR/AND/XOR/NOR mode. The exhaustive
// self-test engine is compiled only when REDUCE_GATE_BIST_EN is defined.
module reduce_gate_bist
   import reduce_pkg::*;
#(
   parameter int unsigned WIDTH       = 4,
   parameter int unsigned HOLD_CYCLES = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       mode,
   output logic             out_valid,
   output logic             out_result,
   input  logic             bist_start,
   input  logic             bist_inject,
   output logic             bist_busy,
   output logic             bist_done,
   output logic             bist_pass,
   output logic [WIDTH:0]   bist_err_count
);

   logic [WIDTH-1:0] core_data;
   logic [1:0]       core_mode;
   logic             core_load;
   logic             core_result;
   logic             accept;
   logic             valid_q;

`ifdef REDUCE_GATE_BIST_EN
   localparam logic [WIDTH:0] V_LAST = {1'b0, {WIDTH{1'b1}}};
   localparam logic [7:0]     H_LAST = 8'(HOLD_CYCLES - 1);

   bist_state_e      state, state_nxt;
   logic             start_acc;
   logic             busy;
   logic             last_hold;
   logic             last_vec;
   logic [WIDTH:0]   vec;
   logic [7:0]       hold;
   logic [1:0]       bmode;
   logic             cmp_pend;
   logic [WIDTH-1:0] cmp_vec;
   logic             mismatch;
   logic [WIDTH:0]   err_run;
   logic [WIDTH:0]   err_next;
   logic [WIDTH:0]   err_out;
   logic             pass_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      start_acc = 1'b0;
      busy      = 1'b0;
      last_hold = (hold == H_LAST);
      last_vec  = (vec == V_LAST);
      case (state)
         ST_IDLE: begin
            if (bist_start) begin
               start_acc = 1'b1;
               state_nxt = ST_APPLY;
            end
         end
         ST_APPLY: begin
            busy = 1'b1;
            if (last_hold && last_vec) begin
               state_nxt = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            busy      = 1'b1;
            state_nxt = ST_DONE;
         end
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // The core output registered on a vector's last hold cycle is checked one cycle later.
   assign mismatch = cmp_pend &&
                     (core_result != (golden_reduce(16'(cmp_vec), WIDTH, bmode) ^ bist_inject));
   assign err_next = (mismatch && (err_run != '1)) ? err_run + 1'b1 : err_run;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vec      <= '0;
         hold     <= '0;
         bmode    <= '0;
         cmp_pend <= 1'b0;
         cmp_vec  <= '0;
         err_run  <= '0;
         err_out  <= '0;
         pass_q   <= 1'b0;
      end else if (start_acc) begin
         vec      <= '0;
         hold     <= '0;
         bmode    <= mode;
         cmp_pend <= 1'b0;
         err_run  <= '0;
         err_out  <= '0;
         pass_q   <= 1'b0;
      end else if (state == ST_APPLY) begin
         err_run  <= err_next;
         cmp_pend <= last_hold;
         cmp_vec  <= vec[WIDTH-1:0];
         if (last_hold) begin
            hold <= '0;
            if (!last_vec) begin
               vec <= vec + 1'b1;
            end
         end else begin
            hold <= hold + 1'b1;
         end
      end else if (state == ST_FLUSH) begin
         err_run  <= err_next;
         cmp_pend <= 1'b0;
         err_out  <= err_next;
         pass_q   <= (err_next == '0);
      end
   end

   assign accept    = in_valid && !busy && !start_acc;
   assign core_data = (state == ST_APPLY) ? vec[WIDTH-1:0] : in_data;
   assign core_mode = (state == ST_APPLY) ? bmode : mode;
   assign core_load = accept || (state == ST_APPLY);

   assign bist_busy      = busy;
   assign bist_done      = (state == ST_DONE);
   assign bist_pass      = pass_q;
   assign bist_err_count = err_out;
`else
   logic unused_bist;

   assign unused_bist    = bist_start ^ bist_inject;
   assign accept         = in_valid;
   assign core_data      = in_data;
   assign core_mode      = mode;
   assign core_load      = in_valid;
   assign bist_busy      = 1'b0;
   assign bist_done      = 1'b0;
   assign bist_pass      = 1'b0;
   assign bist_err_count = '0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
      end else begin
         valid_q <= accept;
      end
   end

   reduce_core #(.WIDTH(WIDTH)) u_core (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (core_load),
      .data   (core_data),
      .mode   (core_mode),
      .result (core_result)
   );

   assign out_valid  = valid_q;
   assign out_result = core_result;

endmodule
